// File: rtl/hm01b0_stream_tx_if.sv
// Control and video bundle for the HM01B0-style parallel video source.
// master = transmitter, slave = downstream receiver / controller.
interface hm01b0_stream_tx_if;
  logic       start;
  logic       continuous;
  logic [1:0] mode;
  logic [7:0] solid_value;
  logic       pixclk;
  logic [7:0] pixdata;
  logic       hsync;
  logic       vsync;
  logic       busy;
  logic       frame_done;

  modport master (
    input  start, continuous, mode, solid_value,
    output pixclk, pixdata, hsync, vsync, busy, frame_done
  );

  modport slave (
    output start, continuous, mode, solid_value,
    input  pixclk, pixdata, hsync, vsync, busy, frame_done
  );
endinterface

// File: rtl/hm01b0_stream_tx.sv
// HM01B0-style parallel video source with programmable geometry and test
// patterns; all video updates land on the pixclk falling edge.
module hm01b0_stream_tx #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int HBLANK = 16,
  parameter int VPORCH = 8,
  parameter int VBLANK = 64,
  parameter int CLKDIV = 4
) (
  input logic               clock,
  input logic               reset,
  hm01b0_stream_tx_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VFRONT = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_HBL    = 3'd3;
  localparam logic [2:0] S_VBL    = 3'd4;

  localparam int CM0 = VPORCH > HBLANK ? VPORCH : HBLANK;
  localparam int CM  = CM0 > VBLANK ? CM0 : VBLANK;
  localparam int DW  = CLKDIV > 1 ? $clog2(CLKDIV) : 1;
  localparam int XW  = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW  = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam int CW  = CM > 1 ? $clog2(CM) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          pclk_q, pclk_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          vs_q, vs_d;
  logic          hs_q, hs_d;
  logic [7:0]    pd_q, pd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pend_q, pend_d;
  logic [7:0]    fc_q, fc_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    solid_q, solid_d;
  logic          tick, fall, launch;

  function automatic logic [7:0] pattern(
    input logic [1:0]    m,
    input logic [7:0]    sv,
    input logic [7:0]    fc,
    input logic [XW-1:0] x,
    input logic [YW-1:0] y
  );
    logic [7:0] r;
    unique case (m)
      2'd0:    r = (((32'(x) >> 3) ^ (32'(y) >> 3)) & 32'd1) != 0
                   ? 8'hFF : 8'h00;
      2'd1:    r = 8'(32'(x));
      2'd2:    r = sv;
      default: r = 8'(32'(fc) + 32'(x) + 32'(y));
    endcase
    return r;
  endfunction

  assign tick   = (div_q == DW'(CLKDIV - 1));
  assign fall   = tick & pclk_q;
  assign div_d  = tick ? '0 : div_q + 1'b1;
  assign pclk_d = tick ? ~pclk_q : pclk_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    vs_d    = vs_q;
    hs_d    = hs_q;
    pd_d    = pd_q;
    busy_d  = busy_q;
    fc_d    = fc_q;
    mode_d  = mode_q;
    solid_d = solid_q;
    done_d  = 1'b0;
    launch  = 1'b0;
    pend_d  = pend_q | (bus.start & (state_q == S_IDLE) & ~busy_q);
    if (fall) begin
      unique case (state_q)
        S_IDLE: launch = pend_q;
        S_VFRONT:
          if (cnt_q == CW'(VPORCH - 1)) begin
            state_d = S_ACTIVE;
            x_d     = '0;
            y_d     = '0;
            hs_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        S_ACTIVE:
          if (x_q == XW'(WIDTH - 1)) begin
            state_d = S_HBL;
            cnt_d   = '0;
            hs_d    = 1'b0;
          end else begin
            x_d = x_q + 1'b1;
          end
        S_HBL:
          if (cnt_q == CW'(HBLANK - 1)) begin
            cnt_d = '0;
            if (y_q != YW'(HEIGHT - 1)) begin
              state_d = S_ACTIVE;
              x_d     = '0;
              y_d     = y_q + 1'b1;
              hs_d    = 1'b1;
            end else begin
              vs_d    = 1'b0;
              done_d  = 1'b1;
              fc_d    = fc_q + 8'd1;
              busy_d  = bus.continuous;
              state_d = bus.continuous ? S_VBL : S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        S_VBL:
          if (cnt_q == CW'(VBLANK - 1)) launch = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        default: begin
          state_d = S_IDLE;
          vs_d    = 1'b0;
          hs_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
      // Launching a frame consumes the pending request so a start that
      // lands on the same clock cannot queue a second frame.
      if (launch) begin
        mode_d  = bus.mode;
        solid_d = bus.solid_value;
        vs_d    = 1'b1;
        hs_d    = 1'b0;
        busy_d  = 1'b1;
        pend_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_VFRONT;
      end
      pd_d = hs_d ? pattern(mode_q, solid_q, fc_q, x_d, y_d) : 8'h00;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      pclk_q  <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      pd_q    <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      fc_q    <= 8'h00;
      mode_q  <= 2'd0;
      solid_q <= 8'h00;
    end else begin
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      pd_q    <= pd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      fc_q    <= fc_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
    end
  end

  assign bus.pixclk     = pclk_q;
  assign bus.pixdata    = pd_q;
  assign bus.hsync      = hs_q;
  assign bus.vsync      = vs_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_hm01b0_stream_tx.sv
// Bench for hm01b0_stream_tx: samples video on pixclk rises and compares
// against a frame-geometry model computed from pixel-period indices.
module tb_hm01b0_stream_tx;
  localparam int W  = 16;
  localparam int H  = 4;
  localparam int HB = 4;
  localparam int VP = 3;
  localparam int VB = 6;
  localparam int CD = 2;
  localparam int FL = VP + H * (W + HB);

  logic clock = 1'b0;
  logic reset = 1'b1;

  hm01b0_stream_tx_if bus ();

  hm01b0_stream_tx #(
    .WIDTH (W),
    .HEIGHT(H),
    .HBLANK(HB),
    .VPORCH(VP),
    .VBLANK(VB),
    .CLKDIV(CD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int fd_exp = 0;
  int frames = 0;

  logic       mon_ok  = 1'b0;
  logic       last_pc = 1'b0;
  logic       last_vs = 1'b0;
  logic [9:0] last_v  = '0;

  // Video changes must coincide with a pixclk fall; frame_done with vsync fall.
  always @(negedge clock) begin
    if (!reset && mon_ok && {bus.vsync, bus.hsync, bus.pixdata} != last_v) begin
      checks++;
      assert (last_pc === 1'b1 && bus.pixclk === 1'b0) else begin
        errors++;
        $error("FAIL edge_align pixclk got %b->%b expected 1->0",
               last_pc, bus.pixclk);
      end
    end
    if (!reset && bus.frame_done === 1'b1) begin
      fd_cnt++;
      checks++;
      assert (last_vs === 1'b1 && bus.vsync === 1'b0) else begin
        errors++;
        $error("FAIL done_vsync vsync got %b->%b expected 1->0",
               last_vs, bus.vsync);
      end
    end
    mon_ok  = !reset;
    last_v  = {bus.vsync, bus.hsync, bus.pixdata};
    last_pc = bus.pixclk;
    last_vs = bus.vsync;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] obs();
    return {bus.busy, bus.vsync, bus.hsync, bus.pixdata};
  endfunction

  // {busy, vsync, hsync, pixdata} for pixel period p of a frame
  function automatic logic [10:0] exp_p(int p, int m, int s, int fc);
    int q, ln, c;
    logic [7:0] d;
    if (p < VP) return {3'b110, 8'h00};
    q  = p - VP;
    ln = q / (W + HB);
    c  = q % (W + HB);
    if (c >= W) return {3'b110, 8'h00};
    case (m)
      0:       d = ((((c >> 3) ^ (ln >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
      1:       d = 8'(c);
      2:       d = 8'(s);
      default: d = 8'(fc + c + ln);
    endcase
    return {3'b111, d};
  endfunction

  task automatic wait_rise();
    logic p;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * CD + 2; i++) begin
      p = bus.pixclk;
      @(posedge clock);
      #1;
      if (bus.pixclk === 1'b1 && p === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL pixclk_rise got none expected rise within %0d clocks",
             4 * CD + 2);
    end
  endtask

  task automatic wait_vsync();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      wait_rise();
      seen = bus.vsync;
    end
    chk("vsync_start", 32'(seen), 32'd1);
  endtask

  task automatic do_start(input int m, input int s, input bit c);
    @(posedge clock);
    #1;
    bus.mode        = 2'(m);
    bus.solid_value = 8'(s);
    bus.continuous  = c;
    bus.start       = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Current sample is period 0; poke >= 0 disturbs inputs mid-frame.
  task automatic check_frame(input int m, input int s, input int poke);
    for (int p = 0; p < FL; p++) begin
      if (p > 0) wait_rise();
      chk($sformatf("f%0d_p%0d", frames, p), 32'(obs()),
          32'(exp_p(p, m, s, frames)));
      if (p == poke) begin
        bus.start       = 1'b1;
        bus.mode        = 2'(m + 1);
        bus.solid_value = 8'(s ^ 255);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
      end
    end
    frames++;
    fd_exp++;
  endtask

  task automatic check_idle_end(input string tag);
    wait_rise();
    chk({tag, "_end"}, 32'(obs()), 32'd0);
    chk({tag, "_done"}, 32'(fd_cnt), 32'(fd_exp));
  endtask

  initial begin
    int   toggles;
    logic pc;
    bit   quiet;
    int   m;
    int   s;

    bus.start       = 1'b0;
    bus.continuous  = 1'b0;
    bus.mode        = 2'd0;
    bus.solid_value = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outs", 32'({bus.pixclk, bus.pixdata, bus.hsync, bus.vsync,
                           bus.busy, bus.frame_done}), 32'd0);
    @(negedge clock) reset = 1'b0;

    pc      = bus.pixclk;
    toggles = 0;
    quiet   = 1'b1;
    repeat (100) begin
      @(posedge clock);
      #1;
      if (bus.pixclk !== pc) toggles++;
      pc = bus.pixclk;
      if (bus.vsync || bus.hsync || bus.busy || bus.pixdata != 0) quiet = 0;
    end
    chk("idle_toggles", 32'(toggles), 32'd50);
    chk("idle_quiet", 32'(quiet), 32'd1);
    chk("idle_done", 32'(fd_cnt), 32'd0);

    do_start(0, 0, 1'b0);
    wait_vsync();
    check_frame(0, 0, -1);
    check_idle_end("m0");

    do_start(1, 0, 1'b0);
    wait_vsync();
    check_frame(1, 0, -1);
    check_idle_end("m1");

    repeat (3) begin
      m = int'($urandom_range(0, 3));
      s = int'($urandom_range(0, 255));
      repeat ($urandom_range(0, 20)) @(posedge clock);
      do_start(m, s, 1'b0);
      wait_vsync();
      check_frame(m, s, -1);
      check_idle_end("rnd");
    end

    s = int'($urandom_range(0, 255));
    do_start(3, s, 1'b1);
    wait_vsync();
    for (int f = 0; f < 3; f++) begin
      check_frame(3, s, -1);
      if (f < 2) begin
        for (int i = 0; i < VB; i++) begin
          wait_rise();
          chk($sformatf("vbl%0d_%0d", f, i), 32'(obs()), 32'h400);
          if (f == 1 && i == 2) bus.continuous = 1'b0;
        end
        wait_rise();
      end
    end
    check_idle_end("cont");

    s = int'($urandom_range(0, 255));
    do_start(2, s, 1'b0);
    wait_vsync();
    check_frame(2, s, 40);
    check_idle_end("poke");
    quiet = 1'b1;
    repeat (30) begin
      wait_rise();
      if (bus.vsync || bus.busy) quiet = 0;
    end
    chk("poke_noextra", 32'(quiet), 32'd1);

    do_start(1, 0, 1'b0);
    wait_vsync();
    for (int p = 1; p <= VP + 2 * (W + HB) + 5; p++) wait_rise();
    chk("pre_reset", 32'({bus.hsync, bus.pixdata}), 32'h105);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", 32'({bus.pixclk, bus.pixdata, bus.hsync, bus.vsync,
                            bus.busy, bus.frame_done}), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("hold_reset", 32'({bus.pixclk, bus.pixdata, bus.hsync, bus.vsync,
                           bus.busy}), 32'd0);
    @(negedge clock) reset = 1'b0;
    frames = 0;

    s = int'($urandom_range(0, 255));
    do_start(3, s, 1'b0);
    wait_vsync();
    check_frame(3, s, -1);
    check_idle_end("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hm01b0_stream_tx.md
Name: hm01b0_stream_tx

Overview:
- Synthesizable HM01B0-style parallel video source: the transmit side of the camera interface the jfpjc ingester receives.
- Drives pixclk/pixdata/hsync/vsync with programmable frame geometry and built-in test patterns.
- Used for on-FPGA loopback into jfpjc and as a clocked replacement for the behavioural camera model in benches.

Parameters:
- WIDTH, 320, active pixels per line
- HEIGHT, 240, active lines per frame
- HBLANK, 16, pixclk periods with hsync low after each line
- VPORCH, 8, pixclk periods with vsync high before the first line
- VBLANK, 64, pixclk periods with vsync low between frames in continuous mode
- CLKDIV, 4, system clocks per pixclk half-period; must be >= 1

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a frame; honoured only when idle
- continuous  in  1  sampled at end of frame; 1 = start the next frame after VBLANK
- mode  in  2  pattern select, latched at frame start
- solid_value  in  8  pixel value for mode 2, latched at frame start
- pixclk  out  1  camera pixel clock, free-running, period 2*CLKDIV clocks
- pixdata  out  8  pixel byte
- hsync  out  1  high while the current line's active pixels are on pixdata
- vsync  out  1  high for the whole frame
- busy  out  1  high from start acceptance until the frame ends and VBLANK completes
- frame_done  out  1  one-clock pulse when vsync falls

Behaviour:
- Reset (async, asserted at any time, including mid-frame):
  - pixclk, pixdata, hsync, vsync, busy and frame_done = 0; state = IDLE; divider, counters and frame counter = 0.
  - Outputs stay at reset values until the next accepted start.
- Divider: a counter counts 0..CLKDIV-1 and raises a tick at CLKDIV-1; pixclk toggles on each tick.
- A "fall event" is a tick that drives pixclk 1->0.
- All state, pixdata, hsync and vsync updates happen only on the clock of a fall event, registered together with the pixclk fall. This makes data stable across every pixclk rising edge.
- start when state = IDLE and busy = 0: latched into start_pending. start while busy is ignored.
- States:
  - IDLE: on a fall event with start_pending set, latch mode and solid_value, set vsync = 1 and busy = 1, clear start_pending, go to VFRONT.
  - VFRONT: VPORCH fall events with hsync = 0, then ACTIVE with x = 0, y = 0.
  - ACTIVE: each fall event presents pixel (x, y) with hsync = 1. After WIDTH pixels: hsync = 0, go to HBL.
  - HBL: HBLANK fall events with hsync = 0. Then:
    - y < HEIGHT-1: y++, x = 0, go to ACTIVE.
    - otherwise: vsync = 0, frame_done pulses on that same clock, frame counter increments (8-bit, wraps), go to VBL if continuous = 1, else IDLE with busy = 0.
  - VBL: VBLANK fall events, then behave as the IDLE start path (new frame, re-latch mode) with busy held high.
- If continuous drops during VBL, the pending frame still runs.
- pixdata is 0 whenever hsync = 0.
- Patterns (8-bit result):
  - mode 0: checkerboard, 0xFF if ((x>>3) ^ (y>>3)) & 1, else 0x00.
  - mode 1: x[7:0].
  - mode 2: solid_value.
  - mode 3: (frame_count + x + y)[7:0].
- Frame length with vsync high: VPORCH + HEIGHT*(WIDTH+HBLANK) pixclk periods.
- Counter widths: $clog2 of each maximum, minimum 1 bit.

Test Plan:
All items use WIDTH=16, HEIGHT=4, HBLANK=4, VPORCH=3, VBLANK=6, CLKDIV=2, so pixclk period = 4 clocks.
- Reset then idle for 100 clocks -> pixclk toggles every 2 clocks; vsync, hsync, pixdata and busy stay 0; no frame_done.
- start with mode 0, continuous 0 -> vsync high for exactly 83 pixclks (332 clocks); hsync high for 4 runs of 16 pixclks. Line 0 samples on pixclk rise: 8x 0x00 then 8x 0xFF. One frame_done pulse; busy falls with vsync.
- mode 1 -> each line samples 0x00..0x0F on successive pixclk rises. pixdata/hsync/vsync transitions always coincide with a pixclk falling edge.
- continuous 1 with mode 3 -> vsync low for exactly 6 pixclks between frames. Frame 1, line 0, pixel 0 = 0x01; frame 2 = 0x02. busy stays high throughout.
- start pulsed mid-frame, mode changed mid-frame -> ignored; current frame keeps its latched pattern; no extra frame afterwards.
- reset asserted at line 2, pixel 5 -> all outputs 0 asynchronously. A fresh start yields a full 83-pixclk frame beginning at line 0.
